// File: rtl/trap_ctrl_if.sv
// Bundle of EXU request/response, CSR file and IFU redirect signals for trap_ctrl.
// slave: the sequencer's view; master: the surrounding EXU/CSR/IFU view.
interface trap_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [DATA_WIDTH-1:0] req_csr;
  logic [DATA_WIDTH-1:0] req_src;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  irq_timer;

  logic [DATA_WIDTH-1:0] csr_addr;
  logic                  csr_wen;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic [DATA_WIDTH-1:0] csr_rdata;

  logic                  intr;
  logic [DATA_WIDTH-1:0] intr_NO;
  logic [DATA_WIDTH-1:0] intr_epc;
  logic [DATA_WIDTH-1:0] intr_mtvec;
  logic                  mret;
  logic [DATA_WIDTH-1:0] mret_mepc;

  logic                  resp_valid;
  logic                  rd_wen;
  logic [DATA_WIDTH-1:0] rd_wdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport slave (
    input  req_valid, req_op, req_csr, req_src, req_pc, irq_timer,
           csr_rdata, intr_mtvec, mret_mepc,
    output req_ready, csr_addr, csr_wen, csr_wdata,
           intr, intr_NO, intr_epc, mret,
           resp_valid, rd_wen, rd_wdata, redirect_valid, redirect_pc
  );

  modport master (
    output req_valid, req_op, req_csr, req_src, req_pc, irq_timer,
           csr_rdata, intr_mtvec, mret_mepc,
    input  req_ready, csr_addr, csr_wen, csr_wdata,
           intr, intr_NO, intr_epc, mret,
           resp_valid, rd_wen, rd_wdata, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// System-instruction sequencer between EXU and the machine-mode CSR file.
// Optional timer-interrupt check stage enabled by defining TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  trap_ctrl_if.slave bus
);

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [DATA_WIDTH-1:0] CSR_MSTATUS = DATA_WIDTH'(12'h300);
  localparam logic [DATA_WIDTH-1:0] CSR_MTVEC   = DATA_WIDTH'(12'h305);
  localparam logic [DATA_WIDTH-1:0] CSR_MEPC    = DATA_WIDTH'(12'h341);
  localparam logic [DATA_WIDTH-1:0] CSR_MCAUSE  = DATA_WIDTH'(12'h342);

  localparam logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL   = DATA_WIDTH'(11);
`ifdef TRAP_CTRL_IRQ_EN
  // Interrupt bit in the MSB, machine timer code 7 in the low bits.
  localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ = {1'b1, {(DATA_WIDTH-4){1'b0}}, 3'b111};
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef TRAP_CTRL_IRQ_EN
    S_IRQ_CHK,
`endif
    S_CSR_RD,
    S_CSR_WR,
    S_TRAP,
    S_MRET
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] csr_q, src_q, pc_q, old_q;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;

  logic [2:0]            disp_op;
  logic [DATA_WIDTH-1:0] disp_csr;
  state_t                disp_state;
  logic [DATA_WIDTH-1:0] disp_cause;
  logic                  accept;

`ifndef TRAP_CTRL_IRQ_EN
  logic unused_irq;
  assign unused_irq = bus.irq_timer;
`endif

  function automatic logic csr_legal(input logic [DATA_WIDTH-1:0] a);
    return (a == CSR_MSTATUS) || (a == CSR_MTVEC) ||
           (a == CSR_MEPC)    || (a == CSR_MCAUSE);
  endfunction

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  // Dispatch decodes the live request in IDLE and the latched one after an
  // interrupt check that found MIE clear, so both paths share one decoder.
  assign disp_op  = (state_q == S_IDLE) ? bus.req_op  : op_q;
  assign disp_csr = (state_q == S_IDLE) ? bus.req_csr : csr_q;

  always_comb begin
    disp_state = S_TRAP;
    disp_cause = CAUSE_ILLEGAL;
    case (disp_op)
      OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
        if (csr_legal(disp_csr)) disp_state = S_CSR_RD;
      end
      OP_ECALL: disp_cause = CAUSE_ECALL;
      OP_MRET:  disp_state = S_MRET;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      csr_q   <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      old_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (accept) begin
        op_q  <= bus.req_op;
        csr_q <= bus.req_csr;
        src_q <= bus.req_src;
        pc_q  <= bus.req_pc;
      end
      if (state_q == S_CSR_RD) old_q <= bus.csr_rdata;
    end
  end

  always_comb begin
    state_d            = state_q;
    cause_d            = cause_q;
    bus.req_ready      = 1'b0;
    bus.csr_addr       = '0;
    bus.csr_wen        = 1'b0;
    bus.csr_wdata      = '0;
    bus.intr           = 1'b0;
    bus.intr_NO        = '0;
    bus.intr_epc       = '0;
    bus.mret           = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.rd_wen         = 1'b0;
    bus.rd_wdata       = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
`ifdef TRAP_CTRL_IRQ_EN
          if (bus.irq_timer) begin
            state_d = S_IRQ_CHK;
          end else begin
            state_d = disp_state;
            cause_d = disp_cause;
          end
`else
          state_d = disp_state;
          cause_d = disp_cause;
`endif
        end
      end

`ifdef TRAP_CTRL_IRQ_EN
      S_IRQ_CHK: begin
        bus.csr_addr = CSR_MSTATUS;
        if (bus.csr_rdata[3]) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IRQ;
        end else begin
          state_d = disp_state;
          cause_d = disp_cause;
        end
      end
`endif

      S_CSR_RD: begin
        bus.csr_addr = csr_q;
        state_d      = S_CSR_WR;
      end

      S_CSR_WR: begin
        bus.csr_addr = csr_q;
        bus.csr_wen  = 1'b1;
        case (op_q)
          OP_CSRRS: bus.csr_wdata = old_q | src_q;
          OP_CSRRC: bus.csr_wdata = old_q & ~src_q;
          default:  bus.csr_wdata = src_q;
        endcase
        bus.resp_valid = 1'b1;
        bus.rd_wen     = 1'b1;
        bus.rd_wdata   = old_q;
        state_d        = S_IDLE;
      end

      S_TRAP: begin
        bus.intr           = 1'b1;
        bus.intr_NO        = cause_q;
        bus.intr_epc       = pc_q;
        bus.resp_valid     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.intr_mtvec;
        state_d            = S_IDLE;
      end

      S_MRET: begin
        bus.mret           = 1'b1;
        bus.resp_valid     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mret_mepc;
        state_d            = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Sequencer sitting between the EXU and the machine-mode CSR file. Accepts one system instruction at a time (CSRRW/CSRRS/CSRRC, ECALL, MRET) plus an optional timer interrupt. Drives the CSR file's read address, write enable, trap-entry (`intr`) and `mret` strobes in a fixed multi-cycle order. Returns the rd writeback value and any PC redirect to the IFU.

## Interface
- `DATA_WIDTH`, 32, width of CSR data, addresses, PC.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  EXU presents a system instruction.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5–7 illegal.
- `req_csr`  in  DATA_WIDTH  CSR address (imm field).
- `req_src`  in  DATA_WIDTH  rs1 value.
- `req_pc`  in  DATA_WIDTH  PC of the instruction.
- `irq_timer`  in  1  level timer interrupt request.
- `csr_addr`  out  DATA_WIDTH  address to CSR file.
- `csr_wen`  out  1  CSR write strobe.
- `csr_wdata`  out  DATA_WIDTH  CSR write data.
- `csr_rdata`  in  DATA_WIDTH  CSR read data, combinational on `csr_addr`.
- `intr`, `intr_NO`, `intr_epc`  out  1/DATA_WIDTH/DATA_WIDTH  trap-entry strobe, cause, EPC.
- `intr_mtvec`  in  DATA_WIDTH  current mtvec.
- `mret`  out  1  mret strobe.
- `mret_mepc`  in  DATA_WIDTH  current mepc.
- `resp_valid`  out  1  one-cycle completion pulse, no back-pressure.
- `rd_wen`, `rd_wdata`  out  1/DATA_WIDTH  GPR writeback.
- `redirect_valid`, `redirect_pc`  out  1/DATA_WIDTH  PC redirect.

## Operation
- States: IDLE, IRQ_CHK, CSR_RD, CSR_WR, TRAP, MRET.
- IDLE: `req_ready`=1. On `req_valid`, latch op/csr/src/pc and go to:
  - IRQ_CHK if `irq_timer`=1.
  - Otherwise, by op: CSRRW/S/C with a legal address goes to CSR_RD. ECALL, an illegal op, or an illegal CSR address goes to TRAP. MRET goes to MRET.
- Legal CSR addresses: 0x300, 0x305, 0x341, 0x342 only.
- IRQ_CHK:
  - `csr_addr`=0x300.
  - If `csr_rdata[3]` (MIE)=1, go to TRAP with cause 0x8000_0007; the instruction is not executed and EPC = latched pc.
  - Otherwise dispatch the latched op as from IDLE.
- CSR_RD: `csr_addr`=latched csr. Capture `csr_rdata` into `old`.
- CSR_WR:
  - `csr_wen`=1, same address.
  - `csr_wdata` is src (RW), old|src (RS), or old&~src (RC). The write is always performed, even when src=0.
  - `resp_valid`=1, `rd_wen`=1, `rd_wdata`=old. Return to IDLE.
- TRAP:
  - `intr`=1. `intr_NO` = 11 (ECALL), 2 (illegal op/address) or 0x8000_0007 (IRQ).
  - `intr_epc`=latched pc.
  - `resp_valid`=1, `redirect_valid`=1, `redirect_pc`=`intr_mtvec`, `rd_wen`=0.
  - Return to IDLE.
- MRET: `mret`=1, `resp_valid`=1, `redirect_valid`=1, `redirect_pc`=`mret_mepc`. Return to IDLE.
- `csr_wen`, `intr` and `mret` are mutually exclusive in every cycle.
- `csr_addr` is 0 when not in IRQ_CHK, CSR_RD or CSR_WR.

## Timing
- Reset (async): state=IDLE. Every output is 0 except `req_ready`=1. `old` and the latched request are cleared.
- Latency from accept edge T:
  - CSR op: `resp_valid` in cycle T+2.
  - ECALL, MRET, illegal: T+1.
  - Add 1 cycle when IRQ_CHK is entered.
- `req_ready` is 0 from T+1 until the cycle after `resp_valid`. Back-to-back requests can therefore be accepted every 2 (trap/mret) or 3 (CSR) cycles.
- `irq_timer` is sampled only at accept. A pulse that falls between accepts is not taken. An interrupt when MIE=0 is dropped for that instruction and re-sampled at the next accept.
- `rst` asserted in any state aborts the operation immediately. No strobe or `resp_valid` is issued for it.

## Configuration
- `TRAP_CTRL_IRQ_EN` defined: the IRQ_CHK state and the `irq_timer` path exist as above.
- Not defined: `irq_timer` is ignored, IRQ_CHK is unreachable and removed, and cause 0x8000_0007 is never produced.

## Test plan
- Reset, then CSRRW csr=0x305 src=0x8000_0100 with the CSR file holding mtvec=0.
  - Expect `csr_wen` at T+2 with wdata 0x8000_0100.
  - Expect `rd_wdata`=0 and `resp_valid` at T+2.
- mtvec=0x0F0F, CSRRS src=0xF000:
  - Expect wdata 0xFF0F and `rd_wdata`=0x0F0F.
  - Follow with CSRRC src=0x000F: expect wdata 0xFF00.
- ECALL pc=0x8000_0040 with mtvec=0x8000_0100:
  - Expect at T+1 `intr`=1, `intr_NO`=11, `intr_epc`=0x8000_0040.
  - Expect `redirect_pc`=0x8000_0100 and no `csr_wen`.
- MRET with mepc=0x8000_0044: expect `mret`=1 and `redirect_pc`=0x8000_0044 at T+1. CSRRW to address 0x344: expect `intr_NO`=2 and no write.
- With the macro defined, mstatus=0x8 and `irq_timer`=1 at accept of a CSRRW:
  - Expect IRQ_CHK, then TRAP with `intr_NO`=0x8000_0007.
  - Expect no `csr_wen`.
  - Repeat with mstatus=0: expect the normal CSRRW at T+3.
- Assert `rst` in CSR_RD: expect `req_ready`=1 and all strobes 0 immediately, with no `resp_valid`.
